// File: rtl/id_ex_stage_pkg.sv
// Shared MIPS constants and the control-bundle layout used by the ID/EX boundary.
package id_ex_stage_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FUNCT_JR = 6'b001000;

    // Field order fixes the bit positions: alu_src is bit 7, jump is bit 0.
    typedef struct packed {
        logic alu_src;
        logic reg_dst;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic reg_write;
        logic branch;
        logic jump;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard detection between the ID instruction and a load sitting in EX.
module load_use_detect
    import id_ex_stage_pkg::*;
(
    input  logic       id_valid,
    input  logic       id_alu_src,
    input  logic       id_mem_write,
    input  logic       id_jump,
    input  logic [5:0] id_opcode,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic       flush,
    output logic       stall
);

    logic uses_rs;
    logic uses_rt;
    logic hz;

    // J/JAL carry a target, not rs; JR is an R-type jump and does read rs.
    assign uses_rs = id_valid & ~(id_jump & (id_opcode != OP_RTYPE));
    assign uses_rt = id_valid & ((~id_alu_src & ~id_jump) | id_mem_write);

    assign hz = ex_valid & ex_mem_read & (ex_rt != 5'd0) &
                ((uses_rs & (ex_rt == id_rs)) | (uses_rt & (ex_rt == id_rt)));

    // A flush kills the ID instruction, so waiting on its operands is pointless.
    assign stall = hz & ~flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and event counters.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              ID_Valid,
    input  logic              ID_ALUSrc,
    input  logic              ID_RegDst,
    input  logic              ID_MemRead,
    input  logic              ID_MemWrite,
    input  logic              ID_MemtoReg,
    input  logic              ID_RegWrite,
    input  logic              ID_Branch,
    input  logic              ID_Jump,
    input  logic [5:0]        ID_OPCode,
    input  logic [5:0]        ID_Funct,
    input  logic [4:0]        ID_Rs,
    input  logic [4:0]        ID_Rt,
    input  logic [4:0]        ID_Rd,
    input  logic [DATA_W-1:0] ID_ReadData1,
    input  logic [DATA_W-1:0] ID_ReadData2,
    input  logic [DATA_W-1:0] ID_SignExtImm,
    input  logic [DATA_W-1:0] ID_PCPlus4,
    input  logic              Flush,
    output logic              Stall,
    output logic              EX_Valid,
    output logic              EX_ALUSrc,
    output logic              EX_RegDst,
    output logic              EX_MemRead,
    output logic              EX_MemWrite,
    output logic              EX_MemtoReg,
    output logic              EX_RegWrite,
    output logic              EX_Branch,
    output logic              EX_Jump,
    output logic [5:0]        EX_OPCode,
    output logic [5:0]        EX_Funct,
    output logic [4:0]        EX_Rs,
    output logic [4:0]        EX_Rt,
    output logic [4:0]        EX_Rd,
    output logic [DATA_W-1:0] EX_ReadData1,
    output logic [DATA_W-1:0] EX_ReadData2,
    output logic [DATA_W-1:0] EX_SignExtImm,
    output logic [DATA_W-1:0] EX_PCPlus4,
    output logic [CNT_W-1:0]  StallCount,
    output logic [CNT_W-1:0]  FlushCount
);

    typedef struct packed {
        logic [5:0]        opcode;
        logic [5:0]        funct;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc4;
    } data_t;

    ctrl_t             id_ctrl;
    data_t             id_data;
    logic              ex_valid_d, ex_valid_q;
    ctrl_t             ex_ctrl_d, ex_ctrl_q;
    data_t             ex_data_d, ex_data_q;
    logic [CNT_W-1:0]  stall_cnt_d, stall_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_d, flush_cnt_q;
    logic              stall;

    assign id_ctrl = '{alu_src: ID_ALUSrc, reg_dst: ID_RegDst, mem_read: ID_MemRead,
                       mem_write: ID_MemWrite, mem_to_reg: ID_MemtoReg,
                       reg_write: ID_RegWrite, branch: ID_Branch, jump: ID_Jump};
    assign id_data = '{opcode: ID_OPCode, funct: ID_Funct, rs: ID_Rs, rt: ID_Rt,
                       rd: ID_Rd, rd1: ID_ReadData1, rd2: ID_ReadData2,
                       imm: ID_SignExtImm, pc4: ID_PCPlus4};

    load_use_detect u_load_use_detect (
        .id_valid     (ID_Valid),
        .id_alu_src   (ID_ALUSrc),
        .id_mem_write (ID_MemWrite),
        .id_jump      (ID_Jump),
        .id_opcode    (ID_OPCode),
        .id_rs        (ID_Rs),
        .id_rt        (ID_Rt),
        .ex_valid     (ex_valid_q),
        .ex_mem_read  (ex_ctrl_q.mem_read),
        .ex_rt        (ex_data_q.rt),
        .flush        (Flush),
        .stall        (stall)
    );

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        ex_valid_d  = ID_Valid;
        ex_ctrl_d   = ID_Valid ? id_ctrl : CTRL_NONE;
        ex_data_d   = id_data;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (Flush) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = CTRL_NONE;
            if (ID_Valid && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end else if (stall) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = CTRL_NONE;
            ex_data_d  = '0;
            if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ex_valid_q  <= 1'b0;
            ex_ctrl_q   <= CTRL_NONE;
            ex_data_q   <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_ctrl_q   <= ex_ctrl_d;
            ex_data_q   <= ex_data_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign Stall         = stall;
    assign EX_Valid      = ex_valid_q;
    assign EX_ALUSrc     = ex_ctrl_q.alu_src;
    assign EX_RegDst     = ex_ctrl_q.reg_dst;
    assign EX_MemRead    = ex_ctrl_q.mem_read;
    assign EX_MemWrite   = ex_ctrl_q.mem_write;
    assign EX_MemtoReg   = ex_ctrl_q.mem_to_reg;
    assign EX_RegWrite   = ex_ctrl_q.reg_write;
    assign EX_Branch     = ex_ctrl_q.branch;
    assign EX_Jump       = ex_ctrl_q.jump;
    assign EX_OPCode     = ex_data_q.opcode;
    assign EX_Funct      = ex_data_q.funct;
    assign EX_Rs         = ex_data_q.rs;
    assign EX_Rt         = ex_data_q.rt;
    assign EX_Rd         = ex_data_q.rd;
    assign EX_ReadData1  = ex_data_q.rd1;
    assign EX_ReadData2  = ex_data_q.rd2;
    assign EX_SignExtImm = ex_data_q.imm;
    assign EX_PCPlus4    = ex_data_q.pc4;
    assign StallCount    = stall_cnt_q;
    assign FlushCount    = flush_cnt_q;

endmodule
